// File: rtl/aes_pkg.sv
// Shared types and constants for the AES output path.
// Block geometry, byte-index type and the serializer FSM encoding.
package aes_pkg;

  localparam int AES_BLOCK_BYTES = 16;
  localparam int AES_BLOCK_W     = 128;
  localparam int BYTE_IDX_W      = 4;

  typedef logic [AES_BLOCK_W-1:0] aes_block_t;
  typedef logic [BYTE_IDX_W-1:0]  byte_idx_t;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_t;

  function automatic logic is_last_byte(input byte_idx_t idx);
    return idx == byte_idx_t'(AES_BLOCK_BYTES - 1);
  endfunction

endpackage

// File: rtl/aes_block_serializer_if.sv
// Block-in / byte-out stream bundle between the AES result path and the TX FIFO.
// The serializer sits on the slave side; the producer/consumer pair is the master.
interface aes_block_serializer_if;
  import aes_pkg::*;

  logic       block_valid;
  aes_block_t block_data;
  logic       block_ready;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_ready;

  modport master (
    output block_valid,
    output block_data,
    output byte_ready,
    input  block_ready,
    input  byte_valid,
    input  byte_data
  );

  modport slave (
    input  block_valid,
    input  block_data,
    input  byte_ready,
    output block_ready,
    output byte_valid,
    output byte_data
  );

endinterface

// File: rtl/aes_byte_select.sv
// Combinational byte lane mux: picks byte idx of a 128-bit block.
// MSB_FIRST=1 maps index 0 to bits [127:120], otherwise to bits [7:0].
module aes_byte_select
  import aes_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b1
) (
  input  aes_block_t data,
  input  byte_idx_t  idx,
  output logic [7:0] byte_out
);

  logic [7:0] lanes [AES_BLOCK_BYTES];

  for (genvar gi = 0; gi < AES_BLOCK_BYTES; gi++) begin : g_lane
    if (MSB_FIRST) begin : g_msb
      assign lanes[gi] = data[AES_BLOCK_W-1-8*gi -: 8];
    end else begin : g_lsb
      assign lanes[gi] = data[8*gi +: 8];
    end
  end

  assign byte_out = lanes[idx];

endmodule

// File: rtl/aes_block_serializer.sv
// Serializes 128-bit AES blocks into a 16-byte valid/ready stream, with a
// one-deep pending buffer so consecutive blocks leave without idle cycles.
module aes_block_serializer
  import aes_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b1,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 n_rst,
  aes_block_serializer_if.slave bus,
  output logic                 busy,
  output logic [CNT_W-1:0]     blocks_sent
);

  ser_state_t state_reg, state_next;
  aes_block_t shift_reg, shift_next;
  aes_block_t pending_reg, pending_next;
  logic       pending_valid_reg, pending_valid_next;
  byte_idx_t  byte_idx_reg, byte_idx_next;
  logic [CNT_W-1:0] blocks_sent_reg, blocks_sent_next;

  logic       in_xfer;
  logic       out_xfer;
  logic       last_xfer;
  logic [7:0] sel_byte;

  // Handshakes derived from registered state only, so block_ready never
  // depends combinationally on byte_ready.
  assign in_xfer   = bus.block_valid & ~pending_valid_reg;
  assign out_xfer  = (state_reg == SEND) & bus.byte_ready;
  assign last_xfer = out_xfer & is_last_byte(byte_idx_reg);

  aes_byte_select #(
    .MSB_FIRST(MSB_FIRST)
  ) u_byte_select (
    .data    (shift_reg),
    .idx     (byte_idx_reg),
    .byte_out(sel_byte)
  );

  always_ff @(posedge clk) begin
    if (n_rst) begin
      state_reg         <= IDLE;
      shift_reg         <= '0;
      pending_reg       <= '0;
      pending_valid_reg <= 1'b0;
      byte_idx_reg      <= '0;
      blocks_sent_reg   <= '0;
    end else begin
      state_reg         <= state_next;
      shift_reg         <= shift_next;
      pending_reg       <= pending_next;
      pending_valid_reg <= pending_valid_next;
      byte_idx_reg      <= byte_idx_next;
      blocks_sent_reg   <= blocks_sent_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (in_xfer) state_next = SEND;
      SEND: if (last_xfer && !pending_valid_reg && !in_xfer) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    shift_next         = shift_reg;
    pending_next       = pending_reg;
    pending_valid_next = pending_valid_reg;
    byte_idx_next      = byte_idx_reg;
    blocks_sent_next   = blocks_sent_reg;

    if (last_xfer) blocks_sent_next = blocks_sent_reg + CNT_W'(1);

    case (state_reg)
      IDLE: begin
        if (in_xfer) begin
          shift_next    = bus.block_data;
          byte_idx_next = '0;
        end
      end
      SEND: begin
        if (last_xfer) begin
          byte_idx_next = '0;
          // A queued block wins; otherwise a block arriving on this very
          // edge bypasses the pending buffer and starts immediately.
          if (pending_valid_reg) begin
            shift_next         = pending_reg;
            pending_valid_next = 1'b0;
          end else if (in_xfer) begin
            shift_next = bus.block_data;
          end
        end else begin
          if (out_xfer) byte_idx_next = byte_idx_reg + byte_idx_t'(1);
          if (in_xfer) begin
            pending_next       = bus.block_data;
            pending_valid_next = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    bus.block_ready = ~pending_valid_reg;
    bus.byte_valid  = (state_reg == SEND);
    bus.byte_data   = (state_reg == SEND) ? sel_byte : 8'h00;
    busy            = (state_reg == SEND) | pending_valid_reg;
    blocks_sent     = blocks_sent_reg;
  end

endmodule

// File: tb/tb_aes_block_serializer.sv
// Directed bench for aes_block_serializer: an MSB-first/16-bit-counter DUT and an
// LSB-first/2-bit-counter DUT share one stimulus stream and are checked side by side.
module tb_aes_block_serializer;

  logic         clk = 1'b0;
  logic         n_rst;
  logic         block_valid;
  logic [127:0] block_data;
  logic         byte_ready;

  always #5 clk = ~clk;

  aes_block_serializer_if bus0 ();
  aes_block_serializer_if bus1 ();

  assign bus0.block_valid = block_valid;
  assign bus0.block_data  = block_data;
  assign bus0.byte_ready  = byte_ready;
  assign bus1.block_valid = block_valid;
  assign bus1.block_data  = block_data;
  assign bus1.byte_ready  = byte_ready;

  logic        block_ready0, block_ready1, byte_valid0, byte_valid1;
  logic [7:0]  byte_data0, byte_data1;
  logic        busy0, busy1;
  logic [15:0] blocks_sent0;
  logic [1:0]  blocks_sent1;

  assign block_ready0 = bus0.block_ready;
  assign block_ready1 = bus1.block_ready;
  assign byte_valid0  = bus0.byte_valid;
  assign byte_valid1  = bus1.byte_valid;
  assign byte_data0   = bus0.byte_data;
  assign byte_data1   = bus1.byte_data;

  aes_block_serializer #(.MSB_FIRST(1'b1), .CNT_W(16)) dut0 (
    .clk(clk), .n_rst(n_rst), .bus(bus0), .busy(busy0), .blocks_sent(blocks_sent0)
  );

  aes_block_serializer #(.MSB_FIRST(1'b0), .CNT_W(2)) dut1 (
    .clk(clk), .n_rst(n_rst), .bus(bus1), .busy(busy1), .blocks_sent(blocks_sent1)
  );

  typedef struct {
    logic [127:0] blk;
    logic [3:0]   pat;       // byte_ready for cycle c is pat[c % 4]
    logic [7:0]   first0, last0, first1, last1;
    int           first_cyc, last_cyc;
  } vec_t;

  vec_t vecs [4];

  int n_tests = 0;
  int n_fail  = 0;
  int exp_sent = 0;

  // Stream stimulus/collection state
  logic [127:0] blk_q [4];
  int           offer_cyc [4];
  int           acc_cyc [4];
  int           nblk;
  logic [3:0]   rdy_pat;
  int           abort_after;
  int           rdy_low;
  logic [7:0]   got0[$];
  logic [7:0]   got1[$];
  int           xfer_cyc[$];

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input logic [127:0] blk, input int k, input bit msb);
    logic [127:0] tmp;
    tmp = msb ? (blk >> (8 * (15 - k))) : (blk >> (8 * k));
    return tmp[7:0];
  endfunction

  task automatic run_stream(input int max_cyc);
    int         cyc;
    int         nxt;
    bit         stall0, stall1, done;
    logic [7:0] pd0, pd1;
    got0.delete();
    got1.delete();
    xfer_cyc.delete();
    cyc = 0; nxt = 0; rdy_low = 0; stall0 = 0; stall1 = 0; done = 0;
    pd0 = '0; pd1 = '0;
    while (!done && cyc < max_cyc) begin
      @(negedge clk);
      if (stall0) check("stall_hold0", {byte_valid0, byte_data0}, {1'b1, pd0});
      if (stall1) check("stall_hold1", {byte_valid1, byte_data1}, {1'b1, pd1});
      block_valid = (nxt < nblk) && (cyc >= offer_cyc[nxt]);
      block_data  = block_valid ? blk_q[nxt] : {$urandom, $urandom, $urandom, $urandom};
      byte_ready  = rdy_pat[cyc % 4];
      if (!block_ready0) rdy_low++;
      if (byte_valid0 && byte_ready) begin
        got0.push_back(byte_data0);
        xfer_cyc.push_back(cyc);
      end
      if (byte_valid1 && byte_ready) got1.push_back(byte_data1);
      stall0 = byte_valid0 && !byte_ready;
      stall1 = byte_valid1 && !byte_ready;
      pd0 = byte_data0;
      pd1 = byte_data1;
      if (block_valid && block_ready0) begin
        acc_cyc[nxt] = cyc;
        nxt++;
      end
      if (abort_after >= 0 && got0.size() == abort_after) done = 1;
      if (nxt == nblk && !busy0 && !block_valid) done = 1;
      cyc++;
    end
    if (!done) check("stream_timeout", 128'(cyc), 128'(max_cyc + 1));
    @(negedge clk);
    block_valid = 1'b0;
    block_data  = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic check_bytes(input string name, input int nb);
    check({name, "_len0"}, 128'(got0.size()), 128'(16 * nb));
    check({name, "_len1"}, 128'(got1.size()), 128'(16 * nb));
    for (int k = 0; k < 16 * nb && k < got0.size() && k < got1.size(); k++) begin
      check($sformatf("%s_b0_%0d", name, k), got0[k], exp_byte(blk_q[k / 16], k % 16, 1'b1));
      check($sformatf("%s_b1_%0d", name, k), got1[k], exp_byte(blk_q[k / 16], k % 16, 1'b0));
    end
  endtask

  task automatic check_count(input string name);
    check({name, "_cnt0"}, blocks_sent0, 128'(exp_sent % 65536));
    check({name, "_cnt1"}, blocks_sent1, 128'(exp_sent % 4));
    check({name, "_busy"}, {busy0, busy1}, 2'b00);
  endtask

  initial begin
    vecs[0] = '{128'h000102030405060708090A0B0C0D0E0F, 4'b1111, 8'h00, 8'h0F, 8'h0F, 8'h00, 1, 16};
    vecs[1] = '{128'h0F0E0D0C0B0A09080706050403020100, 4'b1111, 8'h0F, 8'h00, 8'h00, 8'h0F, 1, 16};
    vecs[2] = '{128'hDEADBEEF0123456789ABCDEFCAFEF00D, 4'b1001, 8'hDE, 8'h0D, 8'h0D, 8'hDE, 3, 32};
    vecs[3] = '{128'h00112233445566778899AABBCCDDEEFF, 4'b0101, 8'h00, 8'hFF, 8'hFF, 8'h00, 2, 32};

    n_rst = 1'b1; block_valid = 1'b0; block_data = '0; byte_ready = 1'b0;
    abort_after = -1;

    // Reset
    repeat (2) @(negedge clk);
    check("rst_block_ready", {block_ready0, block_ready1}, 2'b11);
    check("rst_byte_valid", {byte_valid0, byte_valid1}, 2'b00);
    check("rst_byte_data", {byte_data0, byte_data1}, 16'h0000);
    check("rst_busy", {busy0, busy1}, 2'b00);
    check("rst_cnt", {blocks_sent0, blocks_sent1}, 18'h0);
    n_rst = 1'b0;
    @(negedge clk);
    check("post_rst_idle", {block_ready0, byte_valid0, busy0}, 3'b100);
    $display("[TB] reset released");

    // Single blocks: ordering, latency and backpressure
    for (int v = 0; v < 4; v++) begin
      blk_q[0] = vecs[v].blk; offer_cyc[0] = 0; nblk = 1; rdy_pat = vecs[v].pat;
      run_stream(200);
      exp_sent++;
      check_bytes($sformatf("vec%0d", v), 1);
      if (got0.size() == 16 && got1.size() == 16) begin
        check($sformatf("vec%0d_first0", v), got0[0], vecs[v].first0);
        check($sformatf("vec%0d_last0", v), got0[15], vecs[v].last0);
        check($sformatf("vec%0d_first1", v), got1[0], vecs[v].first1);
        check($sformatf("vec%0d_last1", v), got1[15], vecs[v].last1);
        check($sformatf("vec%0d_first_cyc", v), 128'(xfer_cyc[0]), 128'(vecs[v].first_cyc));
        check($sformatf("vec%0d_last_cyc", v), 128'(xfer_cyc[15]), 128'(vecs[v].last_cyc));
      end
      check($sformatf("vec%0d_acc", v), 128'(acc_cyc[0]), 128'(0));
      check_count($sformatf("vec%0d", v));
      $display("[TB] vec %0d block %h: %0d bytes, blocks_sent=%0d", v, vecs[v].blk, got0.size(), blocks_sent0);
    end

    // Back-to-back: B waits in the pending buffer while A drains
    blk_q[0] = 128'h000102030405060708090A0B0C0D0E0F;
    blk_q[1] = 128'hF0F1F2F3F4F5F6F7F8F9FAFBFCFDFEFF;
    offer_cyc[0] = 0; offer_cyc[1] = 0; nblk = 2; rdy_pat = 4'b1111;
    run_stream(200);
    exp_sent += 2;
    check_bytes("b2b", 2);
    check("b2b_accB", 128'(acc_cyc[1]), 128'(1));
    check("b2b_ready_low", 128'(rdy_low), 128'(15));
    if (xfer_cyc.size() == 32) begin
      check("b2b_B0_cyc", 128'(xfer_cyc[16]), 128'(17));
      check("b2b_span", 128'(xfer_cyc[31] - xfer_cyc[0]), 128'(31));
    end
    check_count("b2b");
    $display("[TB] back-to-back: %0d bytes, blocks_sent=%0d", got0.size(), blocks_sent0);

    // Last-byte collision: B offered exactly as A's byte 15 transfers
    blk_q[0] = 128'h0123456789ABCDEF0011223344556677;
    blk_q[1] = 128'hA5A4A3A2A1A09F9E9D9C9B9A99989796;
    offer_cyc[0] = 0; offer_cyc[1] = 16; nblk = 2; rdy_pat = 4'b1111;
    run_stream(200);
    exp_sent += 2;
    check_bytes("coll", 2);
    check("coll_accB", 128'(acc_cyc[1]), 128'(16));
    check("coll_ready_low", 128'(rdy_low), 128'(0));
    if (xfer_cyc.size() == 32) check("coll_B0_cyc", 128'(xfer_cyc[16]), 128'(17));
    check_count("coll");
    $display("[TB] collision: %0d bytes, blocks_sent=%0d", got0.size(), blocks_sent0);

    // Reset after 5 bytes of a block
    blk_q[0] = 128'h11111111222222223333333344444444;
    offer_cyc[0] = 0; nblk = 1; rdy_pat = 4'b1111; abort_after = 5;
    run_stream(100);
    abort_after = -1;
    check("mid_bytes", 128'(got0.size()), 128'(5));
    n_rst = 1'b1;
    byte_ready = 1'b1;
    @(negedge clk);
    check("mid_rst_valid", {byte_valid0, byte_valid1}, 2'b00);
    check("mid_rst_cnt", {blocks_sent0, blocks_sent1}, 18'h0);
    check("mid_rst_busy_ready", {busy0, busy1, block_ready0, block_ready1}, 4'b0011);
    n_rst = 1'b0;
    exp_sent = 0;
    begin
      int residual;
      residual = 0;
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        if (byte_valid0 || byte_valid1) residual++;
      end
      check("mid_residual", 128'(residual), 128'(0));
    end
    $display("[TB] reset mid-block: blocks_sent=%0d", blocks_sent0);

    // Counter wrap on the 2-bit DUT
    blk_q[0] = 128'hCAFEBABE_00000000_00000000_00000001;
    blk_q[1] = 128'hCAFEBABE_00000000_00000000_00000002;
    blk_q[2] = 128'hCAFEBABE_00000000_00000000_00000003;
    offer_cyc[0] = 0; offer_cyc[1] = 0; offer_cyc[2] = 0; nblk = 3; rdy_pat = 4'b1111;
    run_stream(300);
    exp_sent += 3;
    check_bytes("wrap3", 3);
    check("wrap3_cnt1", blocks_sent1, 2'd3);
    check_count("wrap3");
    $display("[TB] wrap 3 blocks: cnt0=%0d cnt1=%0d", blocks_sent0, blocks_sent1);
    blk_q[0] = 128'hCAFEBABE_00000000_00000000_00000004;
    offer_cyc[0] = 0; nblk = 1;
    run_stream(100);
    exp_sent += 1;
    check_bytes("wrap4", 1);
    check("wrap4_cnt0", blocks_sent0, 16'd4);
    check("wrap4_cnt1", blocks_sent1, 2'd0);
    $display("[TB] wrap 4th block: cnt0=%0d cnt1=%0d", blocks_sent0, blocks_sent1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_block_serializer.md
Name: aes_block_serializer

Overview:
- Sits between the 128-bit AES result (encrypt/decrypt output path) and the byte-wide TX FIFO write port.
- Accepts one 128-bit block per valid/ready handshake and emits it as 16 bytes on a byte-wide valid/ready stream.
- A one-deep pending buffer accepts the next block while the current one drains, so back-to-back blocks stream without bubbles.

Parameters:
- MSB_FIRST, 1, 1: byte 0 sent is bits [127:120]; 0: byte 0 sent is bits [7:0].
- CNT_W, 16, width of the blocks_sent counter.

Ports:
- clk  input  1  system clock, all logic on the rising edge.
- n_rst  input  1  reset, synchronous, active-high (n_rst=1 resets on the next clk edge).
- block_valid  input  1  upstream has a block on block_data.
- block_data  input  128  AES result block.
- block_ready  output  1  serializer can accept a block this cycle.
- byte_valid  output  1  byte_data holds a valid byte.
- byte_data  output  8  current output byte.
- byte_ready  input  1  TX FIFO accepts the byte (i.e. not full).
- busy  output  1  a block is in the shift register or the pending buffer.
- blocks_sent  output  CNT_W  count of fully transmitted blocks, wraps to 0.

Behaviour:
- Reset values: block_ready=1 (comb, from reset state), byte_valid=0, byte_data=0, busy=0, blocks_sent=0. State=IDLE, pending_valid=0, byte_idx=0.
- Handshakes:
  - Input transfer occurs when block_valid & block_ready at a clk edge.
  - Output transfer occurs when byte_valid & byte_ready at a clk edge.
  - byte_data and byte_valid must hold stable while byte_valid=1 and byte_ready=0.
- block_ready = !pending_valid (combinational, registered state only; no combinational path from byte_ready).
- FSM states:
  - IDLE: byte_valid=0. On an input transfer, load the shift register, set byte_idx=0, go to SEND. First byte_valid=1 in the cycle after acceptance (latency 1).
  - SEND: byte_valid=1, byte_data = byte byte_idx of the shift register, using MSB_FIRST ordering. On an output transfer with byte_idx<15, increment byte_idx.
  - SEND, last byte (output transfer with byte_idx=15): blocks_sent increments. Then:
    - if pending_valid: move the pending buffer to the shift register, set byte_idx=0, clear pending_valid, stay in SEND (no bubble);
    - else if an input transfer occurs in the same cycle: load block_data directly, stay in SEND;
    - else go to IDLE.
- Pending buffer:
  - In SEND, an input transfer with pending_valid=0 writes the pending buffer and sets pending_valid.
  - Simultaneous last-byte output and input acceptance while pending_valid=0: the incoming block goes straight to the shift register. It must not be lost or duplicated.
- busy = (state==SEND) | pending_valid.
- blocks_sent wraps from 2^CNT_W-1 to 0.
- byte_ready is ignored while byte_valid=0.
- Reset mid-block: all state is discarded, no partial byte stream is resumed, and the counter is cleared.
- block_data is sampled only on the input transfer edge; later changes have no effect.

Decomposition:
- Shared package aes_pkg holds:
  - AES_BLOCK_BYTES=16, AES_BLOCK_W=128;
  - typedef aes_block_t (logic [127:0]);
  - ser_state_t enum {IDLE, SEND}.
- Byte select (index plus MSB_FIRST ordering) is one natural sub-module: aes_byte_select (combinational mux, 128 in, 4-bit index, 8 out).
- FSM, counter and pending buffer stay in the top module.

Test Plan:
- Reset/single block:
  - Stimulus: assert n_rst=1 for 2 cycles, then send block 0x000102...0F with byte_ready=1 constantly.
  - Response: bytes 00,01,...,0F on 16 consecutive cycles starting one cycle after acceptance; blocks_sent=1; busy falls after byte 0F.
- Back-to-back:
  - Stimulus: block_valid held high with blocks A then B, byte_ready=1.
  - Response: 32 bytes with no idle cycle between A[15] and B[0]; block_ready=0 only while B is pending with A in flight; blocks_sent=2.
- Backpressure:
  - Stimulus: byte_ready toggled 1,0,0,1 repeating.
  - Response: byte_data/byte_valid stable during stalls, no byte skipped or duplicated, 16 bytes total.
- Ordering:
  - Stimulus: MSB_FIRST=0 with block 0x0F0E...00.
  - Response: bytes 00,01,...,0F.
- Last-byte collision:
  - Stimulus: new block offered exactly in the cycle byte 15 transfers, pending empty.
  - Response: next byte 0 of the new block appears the following cycle.
- Reset mid-block and counter wrap:
  - Stimulus: assert n_rst after 5 bytes.
  - Response: byte_valid=0 and blocks_sent=0 next cycle, and no residual bytes afterwards.
  - Stimulus: CNT_W=2, send 4 blocks.
  - Response: blocks_sent returns to 0.
